universal_shift_register: RTL
=============================

Name: universal_shift_register

Overview:
- Parametrised successor to the 8-bit bidirectional serial shift register.
- Adds parallel load, clear, rotate and arithmetic shift operations, plus serial outputs at both ends.
- Adds a multi-cycle burst mode: one shift or rotate op is repeated COUNT times under a start/busy/done handshake.
- Serves as the general shift/rotate datapath element for serialisers, deserialisers and barrel-style sequencing.

Parameters:
- WIDTH, 8, register width in bits (min 2).
- CNT_W, 4, width of the burst count input.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  single-step enable; executes op once per cycle when idle.
- op  input  3  operation select; encoding given under Behaviour.
- sin_l  input  1  serial input entering at the MSB end (SHR).
- sin_r  input  1  serial input entering at the LSB end (SHL).
- pin  input  WIDTH  parallel load data.
- start  input  1  burst request; sampled only when idle.
- count  input  CNT_W  number of burst steps.
- dout  output  WIDTH  register contents.
- sout_l  output  1  dout[WIDTH-1], combinational from the register.
- sout_r  output  1  dout[0], combinational from the register.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Op encoding, applied to register R:
  - 0 HOLD: R unchanged.
  - 1 SHL: {R[W-2:0], sin_r}.
  - 2 SHR: {sin_l, R[W-1:1]}.
  - 3 LOAD: pin.
  - 4 ROL: {R[W-2:0], R[W-1]}.
  - 5 ROR: {R[0], R[W-1:1]}.
  - 6 ASR: {R[W-1], R[W-1:1]}.
  - 7 CLR: all zeros.
- Burst-capable ops are 1, 2, 4, 5 and 6. start with any other op is ignored, and that cycle behaves as a plain en step.
- Reset (rst=0, asynchronous, any state including mid-burst):
  - dout=0, busy=0, done=0, FSM=IDLE, remaining count=0.
  - A burst in progress is aborted; nothing resumes after reset.
- FSM has two states, IDLE and BURST.
- IDLE behaviour:
  - If start=1 and op is burst-capable: latch op and count; no shift on this edge.
  - If the latched count>0, go to BURST; if count=0, stay IDLE, pulse done next cycle, dout unchanged.
  - Otherwise, if en=1, apply op this edge. If en=0, hold.
  - start has priority over en.
- BURST behaviour:
  - Apply the latched op every edge and decrement remaining.
  - sin_l and sin_r are sampled live each cycle.
  - On the edge where remaining goes 1->0: apply the final step, return to IDLE, and register done=1 for exactly one cycle.
  - en, op, start, count and pin are all ignored while in BURST.
- Timing: start sampled at edge E0 gives shifts at E1..E(count).
  - busy=1 during the cycles following E0 through E(count-1), i.e. exactly count cycles.
  - done=1 during the cycle after E(count).
  - The final dout is valid in the same cycle done is high.
- Back-to-back bursts: start is accepted in the cycle done is high, since the FSM is already IDLE.
- busy and done are registered and never high together.
- count=2^CNT_W-1 is legal. A count greater than WIDTH simply continues shifting or rotating, with no saturation.
- Serial ports: sout_l and sout_r always reflect the current dout. Bits shifted out are not otherwise stored.

Test Plan:
- Reset: rst=0 mid-operation -> dout=0x00, busy=0, done=0 immediately, without waiting for a clock edge; en=0 thereafter -> dout holds.
- Single steps (WIDTH=8):
  - LOAD pin=0xB4 -> 0xB4.
  - SHL sin_r=1 -> 0x69.
  - SHR sin_l=0 -> 0x34.
  - CLR -> 0x00.
- Rotate and arithmetic:
  - LOAD 0x81, ROL -> 0x03.
  - ROR -> 0x81.
  - LOAD 0x80, ASR -> 0xC0.
  - Check sout_l=1 and sout_r=0 at 0xC0.
- Burst: LOAD 0x01, then start with op=ROL, count=3, toggling en/op during the burst -> busy high 3 cycles, dout=0x02, 0x04, 0x08, done pulses once with dout=0x08, toggles ignored.
- Zero and back-to-back:
  - start with count=0 -> busy never asserts, done pulses next cycle, dout unchanged.
  - Then start op=SHR count=2 sin_l=1 during the done cycle -> accepted, dout=0xC2 from 0x08.
- Abort: start op=SHL count=5, drive rst=0 after the 2nd shift -> dout=0, busy=0, no done; after release -> IDLE, accepts new start.

Source files
------------

// File: rtl/universal_shift_register.sv
// Purpose: parametrised shift/rotate register with load, clear, serial taps and a counted burst mode.
// Latency: single steps land on the next rising edge; a burst started at E0 shifts on E1..E(count), done follows E(count).
// Backpressure: none; start is only honoured when idle, and en/op/start/count/pin are ignored while busy.
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] dout,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next register value for one application of an operation.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] r,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH-1:0] res;
        res = r;
        case (o)
            OP_HOLD: res = r;
            OP_SHL:  res = {r[WIDTH-2:0], sr};
            OP_SHR:  res = {sl, r[WIDTH-1:1]};
            OP_LOAD: res = p;
            OP_ROL:  res = {r[WIDTH-2:0], r[WIDTH-1]};
            OP_ROR:  res = {r[0], r[WIDTH-1:1]};
            OP_ASR:  res = {r[WIDTH-1], r[WIDTH-1:1]};
            OP_CLR:  res = '0;
            default: res = r;
        endcase
        return res;
    endfunction

    // Only pure shift/rotate ops make sense repeated; LOAD/CLR/HOLD are idempotent.
    function automatic logic burst_capable(input logic [2:0] o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) ||
               (o == OP_ROR) || (o == OP_ASR);
    endfunction

    // Next-state logic: idle single steps / burst launch, burst stepping and completion.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        op_d    = op_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && burst_capable(op)) begin
                    // Launch edge only latches; the first shift happens on the next edge.
                    op_d  = op;
                    rem_d = count;
                    if (count != '0) begin
                        state_d = S_BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    r_d = apply_op(op, r_q, sin_l, sin_r, pin);
                end
            end
            S_BURST: begin
                // Serial inputs are sampled live; all other controls are ignored here.
                r_d   = apply_op(op_q, r_q, sin_l, sin_r, pin);
                rem_d = rem_q - CNT_ONE;
                if (rem_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_BURST);
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            op_q    <= OP_HOLD;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout   = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
